commu_mc_push: RTL and testbench

Multi-channel successor to the single-stream ARM push path. It accepts `CH_NUM` independent 16-bit packet streams and stores one packet per channel in a private word buffer. Ready packets are round-robin arbitrated and served byte-by-byte to the SPI slave interface over the `req_rd`/`req_q` pull port, with `arm_int_n` signalling availability. A microsecond watchdog aborts packets the ARM never drains.

---
 rtl/commu_mc_push.sv | 259 +++++++++++++++++++++++++
 tb/tb_commu_mc_push.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/commu_mc_push.sv
// commu_mc_push: CH_NUM private frame buffers, round-robin served byte-wise over req_rd/req_q (req_q 1 cycle after req_rd).
// Capture never stalls (a frame arriving at a busy buffer is dropped); `COMMU_MC_TP_EN adds a cfg_tp test-pattern mode.
module commu_mc_push #(
  parameter int CH_NUM = 4,
  parameter int DEPTH  = 512,
  parameter int AW     = 9,
  parameter int WD_US  = 1000
) (
  input  logic                  clk_sys,
  input  logic                  rst,
  input  logic [16*CH_NUM-1:0]  repk_data,
  input  logic [CH_NUM-1:0]     repk_vld,
  input  logic [CH_NUM-1:0]     repk_frm,
  input  logic [15:0]           len_pkg,
  input  logic [7:0]            cfg_tp,
  input  logic                  pluse_us,
  input  logic                  req_rd,
  output logic [7:0]            req_q,
  output logic                  arm_int_n,
  output logic [7:0]            stu_buf_rdy,
  output logic [2:0]            cur_ch,
  output logic [15:0]           drop_cnt,
  output logic                  wd_arm_high
);

  localparam int WDW = $clog2(WD_US + 1);
  localparam logic [16:0] MAXLEN = 17'(2 * DEPTH);

  typedef enum logic [1:0] {W_EMPTY, W_FILL, W_READY} wst_t;
  typedef enum logic [1:0] {S_IDLE, S_ARB, S_INT, S_SEND} st_t;

  st_t              r_st, w_st_nx;
  logic [2:0]       r_cur_ch;
  logic [16:0]      r_len;
  logic [17:0]      r_bcnt;
  logic [AW-1:0]    r_raddr;
  logic [AW-1:0]    w_raddr;
  logic [WDW-1:0]   r_wd;
  logic [7:0]       r_q;
  logic             r_wdp;
  logic [15:0]      r_drop;
  logic [CH_NUM-1:0] r_frm_d;

  logic [CH_NUM-1:0] w_ready;
  logic [CH_NUM-1:0] w_drop;
  logic [15:0]       w_rdq  [8];
  logic [AW:0]       w_wcnt [8];
  logic              w_release;

  always_ff @(posedge clk_sys) begin
    if (rst) r_frm_d <= '0;
    else     r_frm_d <= repk_frm;
  end

  genvar gk;
  generate
    for (gk = 0; gk < CH_NUM; gk++) begin : g_ch
      wst_t          r_wst;
      logic [AW:0]   r_wptr;
      logic [AW:0]   r_wcnt;
      logic [15:0]   r_rdq;
      logic [15:0]   r_mem [DEPTH];
      logic          w_rise, w_fall, w_rel, w_we;
      logic [AW:0]   w_wa;

      assign w_rise        = repk_frm[gk] & ~r_frm_d[gk];
      assign w_fall        = ~repk_frm[gk] & r_frm_d[gk];
      assign w_ready[gk]   = (r_wst == W_READY);
      assign w_drop[gk]    = w_rise & (r_wst == W_READY);
      assign w_rel         = w_release & (r_cur_ch == 3'(gk));
      assign w_rdq[gk]     = r_rdq;
      assign w_wcnt[gk]    = r_wcnt;

      // A word arriving with the opening edge lands at address 0.
      always_comb begin
        w_we = 1'b0;
        w_wa = r_wptr;
        if (r_wst == W_EMPTY && w_rise) begin
          w_we = repk_vld[gk];
          w_wa = '0;
        end else if (r_wst == W_FILL && !w_fall) begin
          w_we = repk_vld[gk] & ~r_wptr[AW];
        end
      end

      always_ff @(posedge clk_sys) begin
        if (w_we) r_mem[w_wa[AW-1:0]] <= repk_data[16*gk +: 16];
        r_rdq <= r_mem[w_raddr];
      end

      always_ff @(posedge clk_sys) begin
        if (rst) begin
          r_wst  <= W_EMPTY;
          r_wptr <= '0;
          r_wcnt <= '0;
        end else begin
          case (r_wst)
            W_EMPTY: if (w_rise) begin
              r_wst  <= W_FILL;
              r_wptr <= {{AW{1'b0}}, repk_vld[gk]};
            end
            W_FILL: if (w_fall) begin
              r_wst  <= W_READY;
              r_wcnt <= r_wptr;
            end else if (repk_vld[gk] && !r_wptr[AW]) begin
              r_wptr <= r_wptr + (AW+1)'(1);
            end
            W_READY: if (w_rel) r_wst <= W_EMPTY;
            default: r_wst <= W_EMPTY;
          endcase
        end
      end
    end
    for (gk = CH_NUM; gk < 8; gk++) begin : g_pad
      assign w_rdq[gk]  = '0;
      assign w_wcnt[gk] = '0;
    end
  endgenerate

  logic [3:0]  w_ndrop;
  logic [16:0] w_dsum;
  always_comb begin
    w_ndrop = '0;
    for (int i = 0; i < CH_NUM; i++) w_ndrop = w_ndrop + 4'(w_drop[i]);
    w_dsum = {1'b0, r_drop} + 17'(w_ndrop);
  end

  always_ff @(posedge clk_sys) begin
    if (rst)            r_drop <= '0;
    else if (w_dsum[16]) r_drop <= 16'hFFFF;
    else                r_drop <= w_dsum[15:0];
  end

  // Round-robin: scan starting one past the last served channel.
  logic [7:0] w_rdy8;
  logic [2:0] w_arb_ch;
  logic       w_found;
  always_comb begin
    w_rdy8   = 8'(w_ready);
    w_arb_ch = r_cur_ch;
    w_found  = 1'b0;
    for (int i = 1; i <= CH_NUM; i++) begin
      if (!w_found && w_rdy8[3'((int'(r_cur_ch) + i) % CH_NUM)]) begin
        w_found  = 1'b1;
        w_arb_ch = 3'((int'(r_cur_ch) + i) % CH_NUM);
      end
    end
  end

  logic        w_tp_on, w_tp_sel;
  logic [7:0]  w_tp_cur;
`ifdef COMMU_MC_TP_EN
  logic [7:0]  r_tp;
  logic        r_tp_act;
  assign w_tp_on  = cfg_tp[0];
  assign w_tp_sel = w_tp_on && (r_st == S_IDLE);
  assign w_tp_cur = r_tp_act ? r_tp : {cfg_tp[7:1], 1'b0};
  always_ff @(posedge clk_sys) begin
    if (rst || !w_tp_on) begin
      r_tp     <= '0;
      r_tp_act <= 1'b0;
    end else if (req_rd && w_tp_sel) begin
      r_tp     <= w_tp_cur + 8'd1;
      r_tp_act <= 1'b1;
    end
  end
`else
  logic w_unused_tp;
  assign w_unused_tp = ^cfg_tp;
  assign w_tp_on  = 1'b0;
  assign w_tp_sel = 1'b0;
  assign w_tp_cur = 8'h00;
`endif

  logic [15:0] w_word;
  logic [7:0]  w_pay, w_byte;
  logic        w_last, w_adv, w_wd_hit, w_busy, w_lo;
  logic [16:0] w_len_c;
  logic        w_unused_len;

  assign w_unused_len = r_len[16];
  assign w_len_c  = ({1'b0, len_pkg} > MAXLEN) ? MAXLEN : {1'b0, len_pkg};
  assign w_word   = w_rdq[r_cur_ch];
  assign w_lo     = ~r_bcnt[0];                      // payload byte index = bcnt-3
  assign w_pay    = ({1'b0, r_raddr} >= w_wcnt[r_cur_ch]) ? 8'h00 :
                    (w_lo ? w_word[7:0] : w_word[15:8]);
  assign w_busy   = (r_st == S_INT) || (r_st == S_SEND);
  assign w_last   = (r_bcnt == {1'b0, r_len} + 18'd2);
  assign w_adv    = (r_st == S_SEND) && req_rd && (r_bcnt >= 18'd3) && w_lo;
  assign w_wd_hit = w_busy && !req_rd && pluse_us && (r_wd == WDW'(WD_US - 1));
  assign w_release = ((r_st == S_SEND) && req_rd && w_last) || w_wd_hit;
  // Next word is addressed as the low byte leaves, so back-to-back reads never stall.
  assign w_raddr  = (r_st == S_ARB) ? '0 : (w_adv ? r_raddr + AW'(1) : r_raddr);

  always_comb begin
    w_byte = 8'h00;
    if (w_tp_sel) begin
      w_byte = w_tp_cur;
    end else if (w_busy) begin
      case (r_bcnt)
        18'd0:   w_byte = {4'hA, 1'b0, r_cur_ch};
        18'd1:   w_byte = r_len[15:8];
        18'd2:   w_byte = r_len[7:0];
        default: w_byte = w_pay;
      endcase
    end
  end

  always_comb begin
    w_st_nx = r_st;
    case (r_st)
      S_IDLE: if (|w_ready && !w_tp_on) w_st_nx = S_ARB;
      S_ARB:  w_st_nx = w_found ? S_INT : S_IDLE;
      S_INT:  if (req_rd) w_st_nx = S_SEND;
              else if (w_wd_hit) w_st_nx = S_IDLE;
      S_SEND: if (w_release) w_st_nx = S_IDLE;
      default: w_st_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_st     <= S_IDLE;
      r_cur_ch <= '0;
      r_len    <= '0;
      r_bcnt   <= '0;
      r_raddr  <= '0;
      r_wd     <= '0;
      r_q      <= '0;
      r_wdp    <= 1'b0;
    end else begin
      r_st    <= w_st_nx;
      r_raddr <= w_raddr;
      r_wdp   <= w_wd_hit;
      if (req_rd) r_q <= w_byte;
      if (r_st == S_ARB) begin
        r_cur_ch <= w_arb_ch;
        r_len    <= w_len_c;
        r_bcnt   <= '0;
        r_wd     <= '0;
      end else if (w_busy) begin
        if (req_rd) begin
          r_bcnt <= r_bcnt + 18'd1;
          r_wd   <= '0;
        end else if (pluse_us) begin
          r_wd <= r_wd + WDW'(1);
        end
      end
    end
  end

  assign req_q       = r_q;
  assign arm_int_n   = (r_st != S_INT);
  assign stu_buf_rdy = 8'(w_ready);
  assign cur_ch      = r_cur_ch;
  assign drop_cnt    = r_drop;
  assign wd_arm_high = r_wdp;

endmodule

// File: tb/tb_commu_mc_push.sv
// Bench for commu_mc_push: directed frames, scoreboard of expected req_q bytes checked by a separate monitor.
module tb_commu_mc_push;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [63:0] repk_data;
  logic [3:0]  repk_vld, repk_frm;
  logic [15:0] len_pkg;
  logic [7:0]  cfg_tp;
  logic        pluse_us, req_rd;
  logic [7:0]  req_q;
  logic        arm_int_n;
  logic [7:0]  stu_buf_rdy;
  logic [2:0]  cur_ch;
  logic [15:0] drop_cnt;
  logic        wd_arm_high;

  commu_mc_push #(.CH_NUM(4), .DEPTH(8), .AW(3), .WD_US(3)) dut (
    .clk_sys(clk_sys), .rst(rst), .repk_data(repk_data), .repk_vld(repk_vld),
    .repk_frm(repk_frm), .len_pkg(len_pkg), .cfg_tp(cfg_tp), .pluse_us(pluse_us),
    .req_rd(req_rd), .req_q(req_q), .arm_int_n(arm_int_n), .stu_buf_rdy(stu_buf_rdy),
    .cur_ch(cur_ch), .drop_cnt(drop_cnt), .wd_arm_high(wd_arm_high)
  );

  always #5 clk_sys = ~clk_sys;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] wbuf [16];
  logic        rd_seen = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: each req_rd sampled at a rising edge yields one req_q byte.
  always @(posedge clk_sys) rd_seen <= req_rd;
  always @(negedge clk_sys) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_extra: got %0h expected none", req_q);
      end else begin
        chk("sb_byte", 32'(req_q), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick;
    @(posedge clk_sys); #1;
  endtask

  task automatic send_frame(input logic [3:0] mask, input int n);
    repk_frm = mask; tick;
    for (int i = 0; i < n; i++) begin
      repk_vld = mask; repk_data = {4{wbuf[i]}}; tick;
    end
    repk_vld = '0; repk_frm = '0; tick;
  endtask

  task automatic pull(input int n);
    for (int i = 0; i < n; i++) begin
      req_rd = 1'b1; tick;
    end
    req_rd = 1'b0;
  endtask

  task automatic wait_int(input string nm);
    int n = 0;
    while (arm_int_n !== 1'b0 && n < 40) begin tick; n++; end
    chk(nm, 32'(arm_int_n), 32'd0);
  endtask

  task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c);
  endtask

  initial begin
    rst = 1'b1; repk_data = '0; repk_vld = '0; repk_frm = '0; len_pkg = 16'd8;
    cfg_tp = 8'h00; pluse_us = 1'b0; req_rd = 1'b0;
    repeat (3) tick;
    rst = 1'b0; tick;
    chk("rst_req_q", 32'(req_q), 32'h00);
    chk("rst_arm", 32'(arm_int_n), 32'd1);
    chk("rst_stu", 32'(stu_buf_rdy), 32'h00);
    chk("rst_cur_ch", 32'(cur_ch), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_wd", 32'(wd_arm_high), 32'd0);
    exp_q.push_back(8'h00); pull(1);

    // ch0 basic packet with exact interrupt timing
    wbuf[0] = 16'h1122; wbuf[1] = 16'h3344; wbuf[2] = 16'h5566; wbuf[3] = 16'h7788;
    send_frame(4'b0001, 4);
    chk("t1_stu_set", 32'(stu_buf_rdy), 32'h01);
    chk("t1_arm_e0", 32'(arm_int_n), 32'd1);
    tick; chk("t1_arm_e1", 32'(arm_int_n), 32'd1);
    tick; chk("t1_arm_fall", 32'(arm_int_n), 32'd0);
    push3(8'hA0, 8'h00, 8'h08);
    push3(8'h11, 8'h22, 8'h33); push3(8'h44, 8'h55, 8'h66);
    exp_q.push_back(8'h77); exp_q.push_back(8'h88);
    pull(11);
    chk("t1_stu_clr", 32'(stu_buf_rdy), 32'h00);
    chk("t1_arm_rel", 32'(arm_int_n), 32'd1);

    // round robin: serve ch1, then ch1+ch2 together -> ch2 first
    len_pkg = 16'd2;
    wbuf[0] = 16'h1111; send_frame(4'b0010, 1);
    wait_int("t2a_int");
    push3(8'hA1, 8'h00, 8'h02); exp_q.push_back(8'h11); exp_q.push_back(8'h11);
    pull(5);
    wbuf[0] = 16'h2B2C; send_frame(4'b0110, 1);
    chk("t2_stu_both", 32'(stu_buf_rdy), 32'h06);
    wait_int("t2b_int");
    chk("t2_cur_ch2", 32'(cur_ch), 32'd2);
    push3(8'hA2, 8'h00, 8'h02); exp_q.push_back(8'h2B); exp_q.push_back(8'h2C);
    pull(5);
    wait_int("t2c_int");
    chk("t2_cur_ch1", 32'(cur_ch), 32'd1);
    push3(8'hA1, 8'h00, 8'h02); exp_q.push_back(8'h2B); exp_q.push_back(8'h2C);
    pull(5);

    // drop of a second frame while ch3 is READY
    len_pkg = 16'd4;
    wbuf[0] = 16'h3031; wbuf[1] = 16'h3233; send_frame(4'b1000, 2);
    wbuf[0] = 16'hDEAD; send_frame(4'b1000, 1);
    chk("t3_drop", 32'(drop_cnt), 32'd1);
    wait_int("t3_int");
    push3(8'hA3, 8'h00, 8'h04); push3(8'h30, 8'h31, 8'h32); exp_q.push_back(8'h33);
    pull(7);

    // zero fill beyond stored words
    len_pkg = 16'd6;
    wbuf[0] = 16'hABCD; send_frame(4'b0001, 1);
    wait_int("t4_int");
    push3(8'hA0, 8'h00, 8'h06); push3(8'hAB, 8'hCD, 8'h00); push3(8'h00, 8'h00, 8'h00);
    pull(9);

    // watchdog abort in INT
    wbuf[0] = 16'h5555; send_frame(4'b0010, 1);
    wait_int("t5_int");
    for (int i = 0; i < 3; i++) begin
      pluse_us = 1'b1; tick; pluse_us = 1'b0;
      if (i < 2) chk("t5_wd_early", 32'(wd_arm_high), 32'd0);
      else begin
        chk("t5_wd_pulse", 32'(wd_arm_high), 32'd1);
        chk("t5_stu_clr", 32'(stu_buf_rdy), 32'h00);
        chk("t5_arm_rel", 32'(arm_int_n), 32'd1);
      end
      tick;
    end
    chk("t5_wd_once", 32'(wd_arm_high), 32'd0);

    // buffer saturation (DEPTH=8) and length clamp to 16
    len_pkg = 16'd20;
    for (int i = 0; i < 10; i++) wbuf[i] = {8'(8'h20 + i), 8'(8'h40 + i)};
    send_frame(4'b0100, 10);
    wait_int("t6_int");
    push3(8'hA2, 8'h00, 8'h10);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'(8'h20 + i)); exp_q.push_back(8'(8'h40 + i));
    end
    pull(19);
    chk("t6_stu_clr", 32'(stu_buf_rdy), 32'h00);

`ifdef COMMU_MC_TP_EN
    cfg_tp = 8'h05;
    len_pkg = 16'd2;
    wbuf[0] = 16'h7777; send_frame(4'b0001, 1);
    repeat (3) tick;
    chk("tp_arm_hold", 32'(arm_int_n), 32'd1);
    chk("tp_capture", 32'(stu_buf_rdy), 32'h01);
    exp_q.push_back(8'h04); exp_q.push_back(8'h05); exp_q.push_back(8'h06); exp_q.push_back(8'h07);
    pull(4);
    chk("tp_arm_after", 32'(arm_int_n), 32'd1);
    cfg_tp = 8'h00;
    wait_int("tp_int");
    push3(8'hA0, 8'h00, 8'h02); exp_q.push_back(8'h77); exp_q.push_back(8'h77);
    pull(5);
`endif

    // reset mid-operation
    len_pkg = 16'd2;
    wbuf[0] = 16'h9999; send_frame(4'b0001, 1);
    wait_int("t7_int");
    rst = 1'b1; tick; rst = 1'b0;
    chk("t7_stu", 32'(stu_buf_rdy), 32'h00);
    chk("t7_arm", 32'(arm_int_n), 32'd1);
    chk("t7_drop", 32'(drop_cnt), 32'd0);
    repeat (4) tick;
    chk("t7_idle", 32'(arm_int_n), 32'd1);

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
